// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and state type for the serial binary-to-BCD converter.
//   BCD_DIGIT_W    : width of one BCD digit
//   BCD_ADJ_THRESH : digit value at or above which the add-3 correction applies
//   BCD_ADJ_ADD    : correction amount
//   BCD_NINE       : digit value used when the result saturates
//   state_t        : converter FSM states
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
  localparam logic [3:0] BCD_NINE       = 4'd9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational add-3 correction for one BCD digit of the double-dabble
// algorithm: digits of 5 or more get +3 so the following left shift carries
// correctly into the next decimal digit. Pure 4-bit arithmetic, no carry out.
// Ports:
//   i_digit : scratch digit before correction
//   o_digit : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule : bcd_digit_adj

// File: rtl/bin_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_serial
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock, with start/busy/done handshake. Values that do not fit in DIGITS
// decimal digits saturate to all nines and raise o_overflow.
//
// Optional feature macro: BIN_TO_BCD_BLANK_EN
//   When defined, o_blank (registered leading-zero blank mask) is present.
//
// Parameters:
//   BIN_W  : binary input width (4..32)
//   DIGITS : number of BCD digits produced (1..10)
// Ports:
//   i_clk      : rising-edge clock
//   i_rst      : asynchronous active-high reset
//   i_start    : conversion request, sampled only while idle
//   i_numb     : unsigned binary value, latched on an accepted start
//   o_busy     : conversion in progress
//   o_done     : one-cycle pulse when o_bcd/o_overflow (and o_blank) update
//   o_bcd      : packed BCD result, digit 0 (ones) in bits [3:0]
//   o_overflow : last result was >= 10**DIGITS
//   o_blank    : (BIN_TO_BCD_BLANK_EN only) bit i set when digit i and all
//                higher digits are zero; bit 0 always clear
//
// States:
//   ST_IDLE  | waiting for i_start, outputs held
//   ST_SHIFT | adjusting and shifting one bit per cycle
// -----------------------------------------------------------------------------
module bin_to_bcd_serial
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [BIN_W-1:0]              i_numb,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] o_bcd,
  output logic                          o_overflow
`ifdef BIN_TO_BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]             o_blank
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIN_W-1:0]   r_shreg;
  logic [BCD_W-1:0]   r_scratch;
  logic               r_sticky;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_overflow;
  logic               r_done;

  logic               w_load;
  logic               w_shift;
  logic               w_finish;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_scratch_nxt;
  logic [BIN_W-1:0]   w_shreg_nxt;
  logic               w_sticky_nxt;
  logic [BCD_W-1:0]   w_res_bcd;

  // ---------------------------------------------------------------------------
  // Per-digit add-3 correction on the current scratch digits
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .o_digit (w_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // {scratch, shreg} shifted left by one after correction. The bit leaving the
  // top digit would belong to a digit we do not have, so it marks overflow.
  assign w_scratch_nxt = {w_adj[BCD_W-2:0], r_shreg[BIN_W-1]};
  assign w_shreg_nxt   = {r_shreg[BIN_W-2:0], 1'b0};
  assign w_sticky_nxt  = r_sticky | w_adj[BCD_W-1];

  // Result as it will stand after the final shift, saturated when needed
  assign w_res_bcd = w_sticky_nxt ? {DIGITS{BCD_NINE}} : w_scratch_nxt;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        // Counter reaches zero on this edge: this is the last shift
        if (r_cnt == CNT_W'(1)) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shreg    <= '0;
      r_scratch  <= '0;
      r_sticky   <= 1'b0;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_shreg   <= i_numb;
        r_scratch <= '0;
        r_sticky  <= 1'b0;
        r_cnt     <= CNT_W'(BIN_W);
      end else if (w_shift) begin
        r_shreg   <= w_shreg_nxt;
        r_scratch <= w_scratch_nxt;
        r_sticky  <= w_sticky_nxt;
        r_cnt     <= r_cnt - CNT_W'(1);
      end
      if (w_finish) begin
        r_bcd      <= w_res_bcd;
        r_overflow <= w_sticky_nxt;
      end
    end
  end

  assign o_busy     = (r_state == ST_SHIFT);
  assign o_done     = r_done;
  assign o_bcd      = r_bcd;
  assign o_overflow = r_overflow;

`ifdef BIN_TO_BCD_BLANK_EN
  // ---------------------------------------------------------------------------
  // Leading-zero blank mask, computed from the final scratch and registered
  // alongside the result. Digit 0 is never blanked so zero shows as "0".
  // ---------------------------------------------------------------------------
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_nxt;
  logic              w_zero_above;

  always_comb begin
    w_blank_nxt  = '0;
    w_zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_above   = w_zero_above & (w_scratch_nxt[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
      w_blank_nxt[i] = w_zero_above;
    end
    w_blank_nxt[0] = 1'b0;
    if (w_sticky_nxt) begin
      w_blank_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blank <= BLANK_RST;
    end else if (w_finish) begin
      r_blank <= w_blank_nxt;
    end
  end

  assign o_blank = r_blank;
`endif

endmodule : bin_to_bcd_serial

// File: tb/tb_bin_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_serial
// Drives two converters (DIGITS=5 and DIGITS=3, both BIN_W=16) with the same
// stimulus. A transaction-level model computes each expected result with
// decimal arithmetic and checks every cycle; directed scenarios add literal
// expectations. Define BIN_TO_BCD_BLANK_EN to include the blank mask.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_serial;

  localparam int BIN_W = 16;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic [15:0] numb  = '0;

  always #5 clk = ~clk;

  logic        busy5, done5, ovf5, busy3, done3, ovf3;
  logic [19:0] bcd5;
  logic [11:0] bcd3;
`ifdef BIN_TO_BCD_BLANK_EN
  logic [4:0]  blank5;
  logic [2:0]  blank3;
`endif

  bin_to_bcd_serial #(.BIN_W(BIN_W), .DIGITS(5)) u_d5 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_numb(numb),
    .o_busy(busy5), .o_done(done5), .o_bcd(bcd5), .o_overflow(ovf5)
`ifdef BIN_TO_BCD_BLANK_EN
    , .o_blank(blank5)
`endif
  );

  bin_to_bcd_serial #(.BIN_W(BIN_W), .DIGITS(3)) u_d3 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_numb(numb),
    .o_busy(busy3), .o_done(done3), .o_bcd(bcd3), .o_overflow(ovf3)
`ifdef BIN_TO_BCD_BLANK_EN
    , .o_blank(blank3)
`endif
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dig(input int k);
    return (k == 0) ? 5 : 3;
  endfunction

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [39:0] exp_bcd(input int unsigned v, input int d);
    logic [39:0] r = '0;
    for (int i = 0; i < d; i++) begin
      if (longint'(v) >= pow10(d)) r[4*i +: 4] = 4'd9;
      else r[4*i +: 4] = 4'((longint'(v) / pow10(i)) % 10);
    end
    return r;
  endfunction

  function automatic logic [39:0] exp_blank(input int unsigned v, input int d);
    logic [39:0] r = '0;
    if (longint'(v) < pow10(d))
      for (int i = 1; i < d; i++) r[i] = (longint'(v) < pow10(i));
    return r;
  endfunction

  function automatic logic [39:0] rst_blank(input int d);
    logic [39:0] r = '0;
    for (int i = 1; i < d; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Transaction-level model: accept, wait BIN_W edges, publish decimal result
  logic          m_busy[2], m_done[2], m_ovf[2];
  logic [39:0]   m_bcd[2], m_blank[2];
  int            m_rem[2];
  int unsigned   m_pend[2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k]  <= 1'b0;
        m_done[k]  <= 1'b0;
        m_ovf[k]   <= 1'b0;
        m_bcd[k]   <= '0;
        m_blank[k] <= rst_blank(dig(k));
        m_rem[k]   <= 0;
        m_pend[k]  <= 0;
      end else begin
        m_done[k] <= 1'b0;
        if (m_busy[k]) begin
          if (m_rem[k] == 1) begin
            m_busy[k]  <= 1'b0;
            m_done[k]  <= 1'b1;
            m_bcd[k]   <= exp_bcd(m_pend[k], dig(k));
            m_ovf[k]   <= (longint'(m_pend[k]) >= pow10(dig(k)));
            m_blank[k] <= exp_blank(m_pend[k], dig(k));
          end else begin
            m_rem[k] <= m_rem[k] - 1;
          end
        end else if (start) begin
          m_pend[k] <= int'(numb);
          m_busy[k] <= 1'b1;
          m_rem[k]  <= BIN_W;
        end
      end
    end
  end

  logic [39:0] a_bcd[2];
  logic        a_busy[2], a_done[2], a_ovf[2];
  assign a_bcd[0]  = {20'b0, bcd5};
  assign a_bcd[1]  = {28'b0, bcd3};
  assign a_busy[0] = busy5;
  assign a_busy[1] = busy3;
  assign a_done[0] = done5;
  assign a_done[1] = done3;
  assign a_ovf[0]  = ovf5;
  assign a_ovf[1]  = ovf3;
`ifdef BIN_TO_BCD_BLANK_EN
  logic [39:0] a_blank[2];
  assign a_blank[0] = {35'b0, blank5};
  assign a_blank[1] = {37'b0, blank3};
`endif

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy_d%0d", dig(k)), 40'(a_busy[k]), 40'(m_busy[k]));
        chk($sformatf("done_d%0d", dig(k)), 40'(a_done[k]), 40'(m_done[k]));
        chk($sformatf("bcd_d%0d", dig(k)), a_bcd[k], m_bcd[k]);
        chk($sformatf("ovf_d%0d", dig(k)), 40'(a_ovf[k]), 40'(m_ovf[k]));
`ifdef BIN_TO_BCD_BLANK_EN
        chk($sformatf("blank_d%0d", dig(k)), a_blank[k], m_blank[k]);
`endif
      end
    end
  end

  // One conversion: pulse start for one cycle, wait (bounded) for done on the
  // 5-digit instance, report accept-to-done latency and busy-cycle count.
  task automatic conv(input int unsigned v, output int lat, output int busyc);
    bit got = 1'b0;
    lat   = -1;
    busyc = 0;
    @(negedge clk);
    start = 1'b1;
    numb  = 16'(v);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      busyc += int'(busy5);
      if (done5) begin
        lat = i - 1;
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 40'd0, 40'd1);
  endtask

  int lat, busyc;
  int done_cyc[$];
  int ndone;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_busy", 40'(busy5), 40'd0);
    chk("rst_done", 40'(done5), 40'd0);
    chk("rst_bcd", 40'(bcd5), 40'd0);
    chk("rst_ovf", 40'(ovf5), 40'd0);
`ifdef BIN_TO_BCD_BLANK_EN
    chk("rst_blank", 40'(blank5), 40'b11110);
`endif
    #2 rst = 1'b0;

    conv(0, lat, busyc);
    chk("lat_zero", 40'(lat), 40'd16);
    chk("bcd_zero", 40'(bcd5), 40'h00000);
    chk("ovf_zero", 40'(ovf5), 40'd0);
`ifdef BIN_TO_BCD_BLANK_EN
    chk("blank_zero", 40'(blank5), 40'b11110);
`endif

    conv(65535, lat, busyc);
    chk("bcd_max", 40'(bcd5), 40'h65535);
    chk("ovf_max", 40'(ovf5), 40'd0);
    chk("busy_len", 40'(busyc), 40'd16);
    chk("bcd3_max", 40'(bcd3), 40'h999);

    conv(1234, lat, busyc);
    chk("bcd3_sat", 40'(bcd3), 40'h999);
    chk("ovf3_sat", 40'(ovf3), 40'd1);
    chk("bcd_1234", 40'(bcd5), 40'h01234);
`ifdef BIN_TO_BCD_BLANK_EN
    chk("blank3_sat", 40'(blank3), 40'b000);
`endif

    conv(42, lat, busyc);
    chk("bcd3_42", 40'(bcd3), 40'h042);
    chk("ovf3_42", 40'(ovf3), 40'd0);
    chk("bcd_42", 40'(bcd5), 40'h00042);
`ifdef BIN_TO_BCD_BLANK_EN
    chk("blank_42", 40'(blank5), 40'b11100);
    chk("blank3_42", 40'(blank3), 40'b100);
`endif

    // start held high, numb toggling every cycle
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      numb = (i % 2 == 0) ? 16'd100 : 16'd7;
      @(negedge clk);
      if (done5) done_cyc.push_back(i);
    end
    start = 1'b0;
    chk("b2b_count", 40'(done_cyc.size() >= 3), 40'd1);
    for (int i = 1; i < done_cyc.size(); i++)
      chk("b2b_gap", 40'(done_cyc[i] - done_cyc[i-1]), 40'd17);
    repeat (20) @(negedge clk);

    // reset in the middle of a conversion
    @(negedge clk);
    start = 1'b1;
    numb  = 16'd9999;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 40'(busy5), 40'd0);
    chk("mid_rst_bcd", 40'(bcd5), 40'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ndone += int'(done5);
    end
    chk("no_done_after_rst", 40'(ndone), 40'd0);

    conv(9999, lat, busyc);
    chk("bcd_9999", 40'(bcd5), 40'h09999);
    chk("lat_9999", 40'(lat), 40'd16);

    // randomized conversions with random idle gaps
    for (int n = 0; n < 40; n++) begin
      int unsigned v;
      v = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 999) : $urandom_range(0, 65535);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      conv(v, lat, busyc);
      chk("rand_lat", 40'(lat), 40'd16);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_bin_to_bcd_serial

// File: doc/bin_to_bcd_serial.md
# bin_to_bcd_serial

Sequential, parametrised binary-to-BCD converter for the multi-digit seven-segment display path. It uses the shift-and-add-3 (double-dabble) algorithm, processing one input bit per clock, and exposes a start/busy/done handshake. Width and digit count are generic, and out-of-range inputs saturate with an overflow flag. It sits between the up/down counter value and the per-digit seven-segment decoders.

## Interface
- BIN_W, 16, binary input width; legal range 4..32
- DIGITS, 5, number of BCD digits produced; legal range 1..10
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a conversion; sampled only in IDLE
- numb  in  BIN_W  unsigned binary value; latched on accepted start
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when bcd/overflow are updated
- bcd  out  4*DIGITS  packed result; digit i at bits [4i+3:4i], digit 0 = ones
- overflow  out  1  last result ≥ 10^DIGITS
- blank  out  DIGITS  leading-zero blank mask; present only with BIN_TO_BCD_BLANK_EN

## Operation
- States: IDLE, SHIFT.
- IDLE with start=1: latch numb into the shift register, clear the scratch digits and the sticky overflow bit, load bit counter = BIN_W, go to SHIFT.
- IDLE with start=0: hold all outputs.
- SHIFT, each cycle:
  - Every scratch digit ≥5 gets +3 (4-bit, no carry between digits).
  - {scratch, shreg} shifts left by 1.
  - The bit shifted out of the top digit ORs into sticky overflow.
  - The counter decrements.
- SHIFT with counter reaching 0 on this edge: write the result to bcd and overflow, pulse done, go to IDLE.
- Saturation: if sticky overflow is set, bcd = all digits 9 and overflow = 1. Otherwise bcd = scratch and overflow = 0.
- start while busy is ignored. numb changes during SHIFT have no effect.
- bcd, overflow and blank hold their values until the next done.
- Counter width is $clog2(BIN_W+1). All digit arithmetic is 4-bit unsigned.

## Timing
- Reset values: busy=0, done=0, bcd=0, overflow=0, blank = all ones except bit 0. Internal state is IDLE.
- Sequence, for start accepted at edge N:
  - busy rises after edge N.
  - The last shift happens at edge N+BIN_W.
  - done=1 and the new bcd are visible in the cycle after edge N+BIN_W, with busy=0 in that same cycle.
- Latency is BIN_W cycles from accepting edge to done. Throughput is one conversion per BIN_W+1 cycles at most.
- start high during the done cycle is accepted (back-to-back operation).
- rst mid-conversion: the conversion is immediately abandoned, all outputs take their reset values, and no done is issued.
- done is never asserted for two consecutive cycles.

## Configuration
- BIN_TO_BCD_BLANK_EN defined: the blank port exists and is registered, updating together with bcd.
  - blank[i]=1 iff digit i and all higher digits are 0.
  - blank[0] is always 0, so value 0 shows a single "0".
  - Under overflow, blank = all zeros.
- BIN_TO_BCD_BLANK_EN undefined: the blank port and its logic are absent. All other behaviour is identical.

## Structure
- Package bcd_pkg:
  - BCD_DIGIT_W = 4
  - BCD_ADJ_THRESH = 4'd5
  - BCD_ADJ_ADD = 4'd3
  - BCD_NINE = 4'd9
  - state enum/localparams for IDLE and SHIFT
- Sub-module bcd_digit_adj: combinational 4-bit add-3 correction (in ≥5 → in+3). Generated DIGITS times.
- All remaining logic (FSM, counter, shift register, saturation, blank mask) lives in the top module.

## Test plan
- Defaults; rst, then start with numb=0 → done exactly 16 cycles later; bcd=20'h00000, overflow=0, blank=5'b11110 (blank build).
- numb=16'd65535 → bcd=20'h65535, overflow=0; busy high for exactly 16 cycles.
- DIGITS=3, numb=16'd1234 → bcd=12'h999, overflow=1, blank=3'b000. A following conversion with numb=16'd42 → bcd=12'h042, overflow=0.
- start held high throughout, with numb toggling between 100 and 7 each cycle → only the values latched at accepting edges are converted. Back-to-back done pulses are 17 cycles apart.
- rst pulse at cycle 8 of a conversion of 9999 → outputs return to reset values and no done pulse follows. The next start with numb=9999 gives bcd=20'h09999.
- Blank build, numb=16'd42 → bcd=20'h00042, blank=5'b11100. Non-blank build compiles without the blank port and gives the same bcd.
